regfile_dump_ctrl: RTL and testbench

//  - Debug reader for the core register file: on start, walks addresses 0..NREGS-1 via a read port.
//  - Streams each word out on a valid/ready interface to the debug/trace sink.
//  - Sits beside the register file and drives its A1/A2-style async read port while the core is halted.
//  - Register x0 is read like any other register; the register file returns 0 for it.

---
 rtl/regfile_dump_ctrl.sv | 141 ++++++++++++++
 tb/tb_regfile_dump_ctrl.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_dump_ctrl.sv
// Register file dump controller: walks x0..x(NREGS-1) and streams each word out.
// Optional trailing XOR checksum beat when REGDUMP_CHECKSUM_EN is defined.
module regfile_dump_ctrl #(
   parameter int NREGS = 32,
   parameter int XLEN  = 32,
   parameter int AW    = 5
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   output logic            busy,
   output logic            done,
   output logic [AW-1:0]   rf_addr,
   input  logic [XLEN-1:0] rf_data,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_data,
   output logic [AW-1:0]   out_idx,
   output logic            out_last
);

   typedef enum logic [2:0] {
      IDLE,
      READ,
      SEND,
`ifdef REGDUMP_CHECKSUM_EN
      CSUM,
`endif
      FIN
   } state_t;

   localparam logic [AW-1:0] LAST_IDX = AW'(NREGS - 1);

   state_t          state_q, state_d;
   logic [AW-1:0]   idx_q, idx_d;
   logic [AW-1:0]   rf_addr_q, rf_addr_d;
   logic [XLEN-1:0] data_q, data_d;
   logic [AW-1:0]   oidx_q, oidx_d;
   logic            last_q, last_d;
`ifdef REGDUMP_CHECKSUM_EN
   logic [XLEN-1:0] acc_q, acc_d;
`endif

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      rf_addr_d = rf_addr_q;
      data_d    = data_q;
      oidx_d    = oidx_q;
      last_d    = last_q;
      rf_addr   = rf_addr_q;
`ifdef REGDUMP_CHECKSUM_EN
      acc_d     = acc_q;
`endif
      unique case (state_q)
         IDLE: begin
            if (start) begin
               idx_d   = '0;
               state_d = READ;
`ifdef REGDUMP_CHECKSUM_EN
               acc_d   = '0;
`endif
            end
         end
         READ: begin
            rf_addr   = idx_q;
            rf_addr_d = idx_q;
            data_d    = rf_data;
            oidx_d    = idx_q;
`ifdef REGDUMP_CHECKSUM_EN
            // The checksum beat carries the last flag instead.
            last_d    = 1'b0;
            acc_d     = acc_q ^ rf_data;
`else
            last_d    = (idx_q == LAST_IDX);
`endif
            state_d   = SEND;
         end
         SEND: begin
            if (out_ready) begin
               if (idx_q == LAST_IDX) begin
`ifdef REGDUMP_CHECKSUM_EN
                  data_d  = acc_q;
                  oidx_d  = '0;
                  last_d  = 1'b1;
                  state_d = CSUM;
`else
                  state_d = FIN;
`endif
               end else begin
                  idx_d   = idx_q + 1'b1;
                  state_d = READ;
               end
            end
         end
`ifdef REGDUMP_CHECKSUM_EN
         CSUM: begin
            if (out_ready) state_d = FIN;
         end
`endif
         FIN: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         idx_q     <= '0;
         rf_addr_q <= '0;
         data_q    <= '0;
         oidx_q    <= '0;
         last_q    <= 1'b0;
`ifdef REGDUMP_CHECKSUM_EN
         acc_q     <= '0;
`endif
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         rf_addr_q <= rf_addr_d;
         data_q    <= data_d;
         oidx_q    <= oidx_d;
         last_q    <= last_d;
`ifdef REGDUMP_CHECKSUM_EN
         acc_q     <= acc_d;
`endif
      end
   end

   assign busy      = (state_q != IDLE);
   assign done      = (state_q == FIN);
`ifdef REGDUMP_CHECKSUM_EN
   assign out_valid = (state_q == SEND) || (state_q == CSUM);
`else
   assign out_valid = (state_q == SEND);
`endif
   assign out_data  = data_q;
   assign out_idx   = oidx_q;
   assign out_last  = last_q;

endmodule

// File: tb/tb_regfile_dump_ctrl.sv
// Directed bench for regfile_dump_ctrl with a behavioural register file.
// Beats are recorded at negedge; outputs are checked 1 time unit after posedge.
module tb_regfile_dump_ctrl;

   localparam int NREGS = 32;
   localparam int XLEN  = 32;
   localparam int AW    = 5;
`ifdef REGDUMP_CHECKSUM_EN
   localparam int NBEATS = NREGS + 1;
`else
   localparam int NBEATS = NREGS;
`endif

   logic            clk = 1'b0;
   logic            rst;
   logic            start;
   logic            busy;
   logic            done;
   logic [AW-1:0]   rf_addr;
   logic [XLEN-1:0] rf_data;
   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] out_data;
   logic [AW-1:0]   out_idx;
   logic            out_last;

   logic [XLEN-1:0] rf [NREGS];
   assign rf_data = (rf_addr == '0) ? '0 : rf[rf_addr];

   int checks = 0;
   int errors = 0;

   logic [XLEN-1:0] bd [64];
   logic [AW-1:0]   bi [64];
   logic            bl [64];
   int nb;
   int done_cnt;

   always #5 clk = ~clk;

   regfile_dump_ctrl #(.NREGS(NREGS), .XLEN(XLEN), .AW(AW)) dut (
      .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
      .rf_addr(rf_addr), .rf_data(rf_data),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_idx(out_idx), .out_last(out_last)
   );

   task automatic tick();
      @(negedge clk);
      if (!rst && out_valid && out_ready) begin
         bd[nb] = out_data;
         bi[nb] = out_idx;
         bl[nb] = out_last;
         if (nb < 63) nb++;
      end
      if (done) done_cnt++;
      @(posedge clk);
      #1;
   endtask

   task automatic clear_log();
      nb = 0;
      done_cnt = 0;
   endtask

   task automatic fill_rf(input logic [XLEN-1:0] base);
      for (int i = 0; i < NREGS; i++) rf[i] = base | XLEN'(i);
   endtask

   task automatic start_dump();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_done(output bit to);
      to = 1'b1;
      for (int k = 0; k < 1000; k++) begin
         tick();
         if (done) begin
            to = 1'b0;
            break;
         end
      end
      if (!to) tick();
   endtask

   task automatic wait_beat(input int idx, output bit to);
      to = 1'b1;
      for (int k = 0; k < 1000; k++) begin
         if (out_valid && out_idx == AW'(idx)) begin
            to = 1'b0;
            break;
         end
         tick();
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; out_ready = 1'b1;
      tick(); tick();
      rst = 1'b0;
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_ctl: busy=%b done=%b valid=%b, want 0 0 0",
                  busy, done, out_valid);
      end
      checks++;
      if (out_data !== '0 || out_idx !== '0 || out_last !== 1'b0 ||
          rf_addr !== '0) begin
         errors++;
         $display("FAIL reset_data: data=%h idx=%0d last=%b addr=%0d, want 0",
                  out_data, out_idx, out_last, rf_addr);
      end
   endtask

   task automatic test_latency();
      bit to;
      fill_rf(32'h5A000000);
      clear_log();
      start_dump();
      checks++;
      if (busy !== 1'b1 || out_valid !== 1'b0 || rf_addr !== 5'd0) begin
         errors++;
         $display("FAIL latency_read: busy=%b valid=%b addr=%0d, want 1 0 0",
                  busy, out_valid, rf_addr);
      end
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_idx !== 5'd0 || out_data !== 32'h0) begin
         errors++;
         $display("FAIL latency_send: valid=%b idx=%0d data=%h, want 1 0 0",
                  out_valid, out_idx, out_data);
      end
      wait_done(to);
      checks++;
      if (to || nb != NBEATS) begin
         errors++;
         $display("FAIL latency_done: timeout=%b beats=%0d, want 0 %0d",
                  to, nb, NBEATS);
      end
   endtask

   task automatic test_basic();
      bit to;
      int bad;
      for (int i = 0; i < NREGS; i++) rf[i] = '0;
      rf[1]  = 32'h11111111;
      rf[31] = 32'hDEADBEEF;
      clear_log();
      start_dump();
      wait_done(to);
      checks++;
      if (to || nb != NBEATS || done_cnt != 1) begin
         errors++;
         $display("FAIL basic_count: timeout=%b beats=%0d dones=%0d, want 0 %0d 1",
                  to, nb, done_cnt, NBEATS);
      end
      bad = 0;
      for (int i = 0; i < NREGS; i++) if (bi[i] !== AW'(i)) bad++;
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL basic_order: %0d beats with wrong idx, want 0", bad);
      end
      checks++;
      if (bd[0] !== 32'h0 || bd[1] !== 32'h11111111 || bd[31] !== 32'hDEADBEEF) begin
         errors++;
         $display("FAIL basic_data: b0=%h b1=%h b31=%h, want 0 11111111 deadbeef",
                  bd[0], bd[1], bd[31]);
      end
`ifdef REGDUMP_CHECKSUM_EN
      checks++;
      if (bl[30] !== 1'b0 || bl[31] !== 1'b0 || bl[32] !== 1'b1 ||
          bd[32] !== 32'hCFBCAFFE) begin
         errors++;
         $display("FAIL basic_last: l30=%b l31=%b l32=%b d32=%h, want 0 0 1 cfbcaffe",
                  bl[30], bl[31], bl[32], bd[32]);
      end
`else
      checks++;
      if (bl[30] !== 1'b0 || bl[31] !== 1'b1) begin
         errors++;
         $display("FAIL basic_last: l30=%b l31=%b, want 0 1", bl[30], bl[31]);
      end
`endif
      checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         errors++;
         $display("FAIL basic_idle: busy=%b done=%b, want 0 0", busy, done);
      end
   endtask

   task automatic test_backpressure();
      bit to;
      int bad;
      logic [XLEN-1:0] hd;
      logic [AW-1:0] hi;
      fill_rf(32'hA5000000);
      clear_log();
      start_dump();
      wait_beat(3, to);
      out_ready = 1'b0;
      hd = out_data;
      hi = out_idx;
      for (int c = 0; c < 5; c++) begin
         tick();
         checks++;
         if (out_valid !== 1'b1 || out_data !== hd || out_idx !== hi) begin
            errors++;
            $display("FAIL bp_hold: cyc=%0d valid=%b data=%h idx=%0d, want 1 %h %0d",
                     c, out_valid, out_data, out_idx, hd, hi);
         end
      end
      out_ready = 1'b1;
      wait_done(to);
      bad = 0;
      for (int i = 0; i < NREGS; i++) begin
         if (bi[i] !== AW'(i)) bad++;
         if (i != 0 && bd[i] !== (32'hA5000000 | XLEN'(i))) bad++;
      end
      checks++;
      if (to || nb != NBEATS || bad != 0 || hd !== 32'hA5000003) begin
         errors++;
         $display("FAIL bp_stream: timeout=%b beats=%0d bad=%0d held=%h, want 0 %0d 0 a5000003",
                  to, nb, bad, hd, NBEATS);
      end
   endtask

   task automatic test_restart();
      bit to;
      fill_rf(32'h3C000000);
      clear_log();
      start_dump();
      wait_beat(10, to);
      start = 1'b1;
      tick();
      start = 1'b0;
      wait_done(to);
      checks++;
      if (to || nb != NBEATS || done_cnt != 1 || bi[11] !== 5'd11) begin
         errors++;
         $display("FAIL restart_ignored: timeout=%b beats=%0d dones=%0d, want 0 %0d 1",
                  to, nb, done_cnt, NBEATS);
      end
      tick(); tick();
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL restart_no_requeue: busy=%b, want 0", busy);
      end
   endtask

   task automatic test_midreset();
      bit to;
      fill_rf(32'h77000000);
      clear_log();
      start_dump();
      wait_beat(7, to);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checks++;
      if (to || out_valid !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL midrst_abort: timeout=%b valid=%b busy=%b, want 0 0 0",
                  to, out_valid, busy);
      end
      tick(); tick(); tick();
      checks++;
      if (done_cnt != 0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL midrst_nodone: dones=%0d busy=%b, want 0 0", done_cnt, busy);
      end
      clear_log();
      start_dump();
      wait_done(to);
      checks++;
      if (to || nb != NBEATS || bi[0] !== 5'd0 || bd[8] !== 32'h77000008 ||
          done_cnt != 1) begin
         errors++;
         $display("FAIL midrst_redump: timeout=%b beats=%0d idx0=%0d d8=%h dones=%0d",
                  to, nb, bi[0], bd[8], done_cnt);
      end
   endtask

`ifdef REGDUMP_CHECKSUM_EN
   task automatic test_checksum();
      bit to;
      for (int i = 0; i < NREGS; i++) rf[i] = '0;
      rf[1] = 32'h0000FFFF;
      rf[2] = 32'h00FF00FF;
      clear_log();
      start_dump();
      wait_done(to);
      checks++;
      if (to || nb != 33 || bd[32] !== 32'h00FFFF00 || bi[32] !== 5'd0 ||
          bl[32] !== 1'b1 || bl[31] !== 1'b0) begin
         errors++;
         $display("FAIL csum_beat: beats=%0d d=%h idx=%0d last=%b l31=%b",
                  nb, bd[32], bi[32], bl[32], bl[31]);
      end
   endtask
`endif

   initial begin
      rst = 1'b1;
      start = 1'b0;
      out_ready = 1'b1;
      nb = 0;
      done_cnt = 0;
      for (int i = 0; i < NREGS; i++) rf[i] = '0;
      #1;
      test_reset();
      test_latency();
      test_basic();
      test_backpressure();
      test_restart();
      test_midreset();
`ifdef REGDUMP_CHECKSUM_EN
      test_checksum();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
